// File: rtl/seq_multiplier.sv
// Purpose : unsigned shift-and-add multiplier, one partial product per enabled clock.
// Latency : done and P valid INPUT_SIZE enabled edges after start is accepted; ready again one edge later.
// Backpres: enable=0 freezes every register and output; start is only taken while ready=1 and enable=1.
//
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-low reset
//   enable - global advance; when low, state, datapath and outputs hold
//   start  - begin a multiply (sampled in IDLE only)
//   A, B   - unsigned operands, captured when start is accepted
//   P      - product register, updated only when a multiply completes
//   ready  - FSM is in IDLE
//   busy   - FSM is in BUSY
//   done   - FSM is in DONE (one enabled cycle)
module seq_multiplier #(
    parameter int INPUT_SIZE = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      start,
    input  logic [INPUT_SIZE-1:0]     A,
    input  logic [INPUT_SIZE-1:0]     B,
    output logic [2*INPUT_SIZE-1:0]   P,
    output logic                      ready,
    output logic                      busy,
    output logic                      done
);

    localparam int CNT_W = $clog2(INPUT_SIZE + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]              state;
    logic [INPUT_SIZE-1:0]   mcand;
    logic [INPUT_SIZE-1:0]   mplier;
    logic [2*INPUT_SIZE-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    logic [INPUT_SIZE-1:0]   addend;
    logic [INPUT_SIZE:0]     psum;
    logic [2*INPUT_SIZE-1:0] acc_step;
    logic                    last_iter;

    // One shift-and-add step. The add keeps its carry so that the right
    // shift of {carry, acc} never loses a bit; after INPUT_SIZE steps the
    // accumulator holds the full double-width product.
    always_comb begin
        addend    = mplier[0] ? mcand : '0;
        psum      = {1'b0, acc[2*INPUT_SIZE-1:INPUT_SIZE]} + {1'b0, addend};
        acc_step  = {psum, acc[INPUT_SIZE-1:1]};
        last_iter = (cnt == CNT_W'(1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            P      <= '0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        cnt    <= CNT_W'(INPUT_SIZE);
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    // Fixed iteration count: no early exit on zero operands.
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (last_iter) begin
                        P     <= acc_step;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Status outputs are pure state decodes, so reset clears them at once.
    always_comb begin
        ready = (state == IDLE);
        busy  = (state == BUSY);
        done  = (state == DONE);
    end

endmodule
